// File: rtl/cal_month_roll_ctrl.sv
// -----------------------------------------------------------------------------
// cal_month_roll_ctrl
// Display-side sequencer for the month-name pixel memory in the calendar area.
// Maps raster coordinates into window-relative memory coordinates, re-aligns
// the 1-cycle memory read latency, and on a month change plays a frame-paced
// vertical roll: the old name scrolls up and out, then the new name scrolls
// up and in. The name is never swapped partway through a frame.
//
// Ports:
//   clk_i          pixel clock
//   rst_i          synchronous reset, active-high
//   month_i        requested month (level); values >= MONTH_CNT are ignored
//   frame_start_i  one-cycle pulse at the start of each frame
//   pix_x_i/_y_i   raster coordinates
//   pix_de_i       raster data-enable
//   mem_month_o    month select to the pixel memory
//   mem_pos_x_o/_y_o memory coordinates
//   mem_pix_i      memory pixel, valid 1 cycle after address/month presented
//   pix_o          window pixel (0 when blank or outside the window)
//   pix_de_o       pix_de_i delayed by 2 cycles
//   roll_busy_o    high while a roll is in progress
//   disp_month_o   month currently shown
// -----------------------------------------------------------------------------
module cal_month_roll_ctrl #(
  parameter int MONTH_CNT    = 12,
  parameter int MONTH_W      = $clog2(MONTH_CNT),
  parameter int PIX_X_W      = 12,
  parameter int PIX_Y_W      = 12,
  parameter int WIN_X        = 200,
  parameter int WIN_Y        = 40,
  parameter int IMG_W        = 130,
  parameter int IMG_H        = 30,
  parameter int MEM_X_OFFSET = 84,
  parameter int ROLL_STEP    = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [MONTH_W-1:0] month_i,
  input  logic               frame_start_i,
  input  logic [PIX_X_W-1:0] pix_x_i,
  input  logic [PIX_Y_W-1:0] pix_y_i,
  input  logic               pix_de_i,
  output logic [MONTH_W-1:0] mem_month_o,
  output logic [PIX_X_W-1:0] mem_pos_x_o,
  output logic [PIX_Y_W-1:0] mem_pos_y_o,
  input  logic               mem_pix_i,
  output logic               pix_o,
  output logic               pix_de_o,
  output logic               roll_busy_o,
  output logic [MONTH_W-1:0] disp_month_o
);

  // One extra bit on coordinate math so window bounds and ry + off never wrap.
  localparam int XW  = PIX_X_W + 1;
  localparam int YW  = PIX_Y_W + 1;
  localparam int MW1 = MONTH_W + 1;

  localparam logic [XW-1:0]      X_LO   = XW'(WIN_X);
  localparam logic [XW-1:0]      X_HI   = XW'(WIN_X + IMG_W);
  localparam logic [YW-1:0]      Y_LO   = YW'(WIN_Y);
  localparam logic [YW-1:0]      Y_HI   = YW'(WIN_Y + IMG_H);
  localparam logic [PIX_X_W-1:0] X_LO_N = PIX_X_W'(WIN_X);
  localparam logic [PIX_X_W-1:0] MEM_XO = PIX_X_W'(MEM_X_OFFSET);
  localparam logic [YW-1:0]      IMG_HY = YW'(IMG_H);
  localparam logic [YW-1:0]      STEP_Y = YW'(ROLL_STEP);
  localparam logic [MW1-1:0]     MCNT   = MW1'(MONTH_CNT);

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    ROLL_OUT = 2'd1,
    ROLL_IN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [YW-1:0]      off_q, off_d;
  logic [MONTH_W-1:0] disp_q, disp_d;
  logic [MONTH_W-1:0] target_q, target_d;
  logic               busy_q;

  logic [MONTH_W-1:0] tgt_s;
  logic [YW-1:0]      off_up_s;

  logic [YW-1:0]      y_ext_s;
  logic [XW-1:0]      xw_s;
  logic               in_win_s;
  logic [PIX_X_W-1:0] rx_s;
  logic [YW-1:0]      ry_s;
  logic [YW-1:0]      sum_out_s;
  logic [PIX_Y_W-1:0] my_s;
  logic               blank_s;
  logic               vis_s;

  logic [MONTH_W-1:0] mem_month_q;
  logic [PIX_X_W-1:0] mem_x_q;
  logic [PIX_Y_W-1:0] mem_y_q;
  logic               vis_q;
  logic               vis_d_q;
  logic               de1_q;
  logic               de2_q;

  // Target seen by this frame_start: a valid month_i takes effect immediately.
  assign tgt_s    = ({1'b0, month_i} < MCNT) ? month_i : target_q;
  assign off_up_s = off_q + STEP_Y;

  // Roll sequencer next-state: everything advances only on frame_start_i.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    disp_d   = disp_q;
    target_d = target_q;
    if (frame_start_i) begin
      target_d = tgt_s;
      case (state_q)
        SHOW: begin
          if (tgt_s != disp_q) begin
            state_d = ROLL_OUT;
            off_d   = '0;
          end else begin
            state_d = SHOW;
          end
        end
        ROLL_OUT: begin
          // Swap uses whatever target is current at swap time.
          if (off_up_s >= IMG_HY) begin
            off_d   = IMG_HY;
            disp_d  = tgt_s;
            state_d = ROLL_IN;
          end else begin
            off_d   = off_up_s;
          end
        end
        ROLL_IN: begin
          if (off_q <= STEP_Y) begin
            off_d   = '0;
            state_d = (tgt_s != disp_q) ? ROLL_OUT : SHOW;
          end else begin
            off_d   = off_q - STEP_Y;
          end
        end
        default: begin
          state_d = SHOW;
          off_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Roll sequencer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SHOW;
      off_q    <= '0;
      disp_q   <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      disp_q   <= disp_d;
      target_q <= target_d;
      busy_q   <= (state_d != SHOW);
    end
  end

  // Window test and row mapping; uses the pre-update state/off on frame_start.
  always_comb begin
    xw_s      = {1'b0, pix_x_i};
    y_ext_s   = {1'b0, pix_y_i};
    in_win_s  = pix_de_i && (xw_s >= X_LO) && (xw_s < X_HI) &&
                (y_ext_s >= Y_LO) && (y_ext_s < Y_HI);
    rx_s      = pix_x_i - X_LO_N;
    ry_s      = y_ext_s - Y_LO;
    sum_out_s = ry_s + off_q;
    blank_s   = 1'b0;
    my_s      = ry_s[PIX_Y_W-1:0];
    case (state_q)
      SHOW: begin
        blank_s = 1'b0;
      end
      ROLL_OUT: begin
        blank_s = (sum_out_s >= IMG_HY);
        my_s    = sum_out_s[PIX_Y_W-1:0];
      end
      ROLL_IN: begin
        blank_s = (ry_s < off_q);
        my_s    = ry_s[PIX_Y_W-1:0] - off_q[PIX_Y_W-1:0];
      end
      default: begin
        blank_s = 1'b1;
      end
    endcase
    vis_s = in_win_s && !blank_s;
  end

  // Stage 1: memory drive (held while not visible) plus vis/de pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_month_q <= '0;
      mem_x_q     <= '0;
      mem_y_q     <= '0;
      vis_q       <= 1'b0;
      de1_q       <= 1'b0;
    end else begin
      if (vis_s) begin
        mem_month_q <= disp_q;
        mem_x_q     <= rx_s + MEM_XO;
        mem_y_q     <= my_s;
      end
      vis_q <= vis_s;
      de1_q <= pix_de_i;
    end
  end

  // Stage 2: align vis and de with the memory's one-cycle read latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vis_d_q <= 1'b0;
      de2_q   <= 1'b0;
    end else begin
      vis_d_q <= vis_q;
      de2_q   <= de1_q;
    end
  end

  assign mem_month_o  = mem_month_q;
  assign mem_pos_x_o  = mem_x_q;
  assign mem_pos_y_o  = mem_y_q;
  assign pix_o        = vis_d_q & mem_pix_i;
  assign pix_de_o     = de2_q;
  assign roll_busy_o  = busy_q;
  assign disp_month_o = disp_q;

endmodule

// File: tb/tb_cal_month_roll_ctrl.sv
// Self-checking bench for cal_month_roll_ctrl: table of window/mapping vectors
// in SHOW, then hand-written roll sequences (full roll, retarget during roll,
// out-of-range month, frame_start coincident with a pixel, reset mid-roll).
module tb_cal_month_roll_ctrl;

  localparam int MW = 4;
  localparam int XW = 12;
  localparam int YW = 12;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [MW-1:0] month_i = '0;
  logic          frame_start_i = 1'b0;
  logic [XW-1:0] pix_x_i = '0;
  logic [YW-1:0] pix_y_i = '0;
  logic          pix_de_i = 1'b0;
  logic [MW-1:0] mem_month_o;
  logic [XW-1:0] mem_pos_x_o;
  logic [YW-1:0] mem_pos_y_o;
  logic          mem_pix_i = 1'b1;
  logic          pix_o;
  logic          pix_de_o;
  logic          roll_busy_o;
  logic [MW-1:0] disp_month_o;

  cal_month_roll_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .month_i      (month_i),
    .frame_start_i(frame_start_i),
    .pix_x_i      (pix_x_i),
    .pix_y_i      (pix_y_i),
    .pix_de_i     (pix_de_i),
    .mem_month_o  (mem_month_o),
    .mem_pos_x_o  (mem_pos_x_o),
    .mem_pos_y_o  (mem_pos_y_o),
    .mem_pix_i    (mem_pix_i),
    .pix_o        (pix_o),
    .pix_de_o     (pix_de_o),
    .roll_busy_o  (roll_busy_o),
    .disp_month_o (disp_month_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int    x;
    int    y;
    bit    mpix;
    bit    epix;
    int    emx;
    int    emy;
    string name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold one pixel for two cycles, then check the pipelined result.
  task automatic probe(input int x, input int y, input bit mpix, input bit epix,
                       input int emx, input int emy, input int emon, input string tag);
    @(negedge clk_i);
    pix_x_i = XW'(x); pix_y_i = YW'(y); pix_de_i = 1'b1; mem_pix_i = mpix;
    @(negedge clk_i);
    @(negedge clk_i);
    chk({tag, ".pix"}, pix_o, epix);
    chk({tag, ".de"}, pix_de_o, 1);
    chk({tag, ".mx"}, mem_pos_x_o, emx);
    chk({tag, ".my"}, mem_pos_y_o, emy);
    chk({tag, ".mon"}, mem_month_o, emon);
    pix_de_i = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk_i);
    frame_start_i = 1'b1;
    @(negedge clk_i);
    frame_start_i = 1'b0;
  endtask

  // frame_start in the same cycle as an in-window pixel at row 0.
  task automatic frame_pix(input int exp_my);
    @(negedge clk_i);
    frame_start_i = 1'b1;
    pix_x_i = 12'd210; pix_y_i = 12'd40; pix_de_i = 1'b1; mem_pix_i = 1'b1;
    @(negedge clk_i);
    frame_start_i = 1'b0;
    pix_de_i = 1'b0;
    @(negedge clk_i);
    chk("coinc.my", mem_pos_y_o, exp_my);
    chk("coinc.pix", pix_o, 1);
  endtask

  task automatic chk_state(input string tag, input int busy, input int disp);
    chk({tag, ".busy"}, roll_busy_o, busy);
    chk({tag, ".disp"}, disp_month_o, disp);
  endtask

  initial begin
    vecs[0] = '{210, 45, 1'b1, 1'b1,  94,  5, "v_inwin"};
    vecs[1] = '{199, 45, 1'b1, 1'b0,  94,  5, "v_left"};
    vecs[2] = '{330, 45, 1'b1, 1'b0,  94,  5, "v_right"};
    vecs[3] = '{329, 69, 1'b1, 1'b1, 213, 29, "v_corner"};
    vecs[4] = '{200, 40, 1'b0, 1'b0,  84,  0, "v_mem0"};
    vecs[5] = '{250, 70, 1'b1, 1'b0,  84,  0, "v_below"};
    vecs[6] = '{250, 39, 1'b1, 1'b0,  84,  0, "v_above"};
    vecs[7] = '{260, 50, 1'b1, 1'b1, 144, 10, "v_mid"};

    // Reset values.
    repeat (3) @(negedge clk_i);
    chk("rst.pix", pix_o, 0);
    chk("rst.de", pix_de_o, 0);
    chk("rst.mx", mem_pos_x_o, 0);
    chk("rst.my", mem_pos_y_o, 0);
    chk("rst.mon", mem_month_o, 0);
    chk_state("rst", 0, 0);
    rst_i = 1'b0;

    // Window mapping in SHOW.
    for (int i = 0; i < 8; i++) begin
      probe(vecs[i].x, vecs[i].y, vecs[i].mpix, vecs[i].epix,
            vecs[i].emx, vecs[i].emy, 0, vecs[i].name);
    end

    // Exact 2-cycle de delay for an outside-window single-cycle pulse.
    repeat (2) @(negedge clk_i);
    pix_x_i = 12'd199; pix_y_i = 12'd45; pix_de_i = 1'b1; mem_pix_i = 1'b1;
    @(negedge clk_i);
    pix_de_i = 1'b0;
    chk("de.d1", pix_de_o, 0);
    @(negedge clk_i);
    chk("de.d2", pix_de_o, 1);
    chk("de.pix", pix_o, 0);
    @(negedge clk_i);
    chk("de.d3", pix_de_o, 0);

    // Full roll 0 -> 4.
    month_i = 4'd4;
    frame();
    chk_state("ro.start", 1, 0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) frame_pix(12);
      else frame();
      chk_state("ro", 1, (k == 10) ? 4 : 0);
      if (k < 10) probe(210, 40, 1'b1, 1'b1, 94, 3 * k, 0, "ro.row0");
      if (k == 2) begin
        probe(210, 60, 1'b1, 1'b1, 94, 26, 0, "ro.ry20");
        probe(210, 65, 1'b1, 1'b0, 94, 26, 0, "ro.ry25");
      end
    end
    probe(210, 69, 1'b1, 1'b0, 94, 27, 0, "swap.blank");
    for (int k = 1; k <= 10; k++) begin
      frame();
      chk_state("ri", (k < 10) ? 1 : 0, 4);
      probe(210, 69, 1'b1, 1'b1, 94, 3 * k - 1, 4, "ri.row29");
    end

    // Retarget during ROLL_OUT (5 -> 7) and during ROLL_IN (7 -> 2).
    month_i = 4'd5;
    frame();
    chk_state("rt.start", 1, 4);
    for (int k = 1; k <= 3; k++) frame();
    month_i = 4'd7;
    for (int k = 1; k <= 7; k++) begin
      frame();
      chk_state("rt.out", 1, (k == 7) ? 7 : 4);
    end
    for (int k = 1; k <= 3; k++) frame();
    month_i = 4'd2;
    for (int k = 1; k <= 7; k++) begin
      frame();
      chk_state("rt.in", 1, 7);
    end
    probe(210, 45, 1'b1, 1'b1, 94, 5, 7, "rt.reout");
    for (int k = 1; k <= 10; k++) frame();
    chk_state("rt.swap2", 1, 2);
    for (int k = 1; k <= 10; k++) frame();
    chk_state("rt.done", 0, 2);

    // Out-of-range month ignored.
    month_i = 4'd13;
    frame();
    chk_state("oor.f1", 0, 2);
    frame();
    chk_state("oor.f2", 0, 2);

    // Reset in ROLL_OUT at off = 15.
    month_i = 4'd9;
    frame();
    for (int k = 1; k <= 5; k++) frame();
    probe(210, 40, 1'b1, 1'b1, 94, 15, 2, "mid.off15");
    @(negedge clk_i);
    rst_i = 1'b1; mem_pix_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk_state("mid.rst", 0, 0);
    chk("mid.pix", pix_o, 0);
    chk("mid.de", pix_de_o, 0);
    chk("mid.mx", mem_pos_x_o, 0);
    chk("mid.my", mem_pos_y_o, 0);
    chk("mid.mon", mem_month_o, 0);
    month_i = 4'd0;
    frame();
    chk_state("post.rst", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cal_month_roll_ctrl.md
Name: cal_month_roll_ctrl

Overview:
Display-side sequencer for the month-name pixel memory block in the calendar area.
- Maps raster coordinates into window-relative memory coordinates and drives month selection.
- Re-aligns the 1-cycle memory read latency with a matching data-enable.
- When the calendar month changes, runs a frame-paced vertical roll (old name scrolls up and out, new name scrolls up and in), so the name never swaps mid-frame.

Parameters:
MONTH_CNT, 12, number of months; MONTH_W = $clog2(MONTH_CNT)
PIX_X_W, 12, raster/memory x coordinate width
PIX_Y_W, 12, raster/memory y coordinate width
WIN_X, 200, screen x of window left column
WIN_Y, 40, screen y of window top row
IMG_W, 130, window width in pixels
IMG_H, 30, window height in pixels
MEM_X_OFFSET, 84, constant added to window-relative x before driving memory x
ROLL_STEP, 3, rows scrolled per frame during a roll (1..IMG_H)

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  synchronous reset, active-high
month_i  in  MONTH_W  requested month from calendar logic (level)
frame_start_i  in  1  one-cycle pulse at start of each frame
pix_x_i  in  PIX_X_W  raster x
pix_y_i  in  PIX_Y_W  raster y
pix_de_i  in  1  raster data-enable
mem_month_o  out  MONTH_W  month select to pixel memory
mem_pos_x_o  out  PIX_X_W  memory x
mem_pos_y_o  out  PIX_Y_W  memory y
mem_pix_i  in  1  memory pixel; valid 1 cycle after address/month presented
pix_o  out  1  window pixel (0 when blank/outside)
pix_de_o  out  1  pix_de_i delayed 2 cycles
roll_busy_o  out  1  high while a roll is in progress
disp_month_o  out  MONTH_W  month currently shown

Behaviour:
- Reset values: state SHOW, disp_month = 0, target = 0, off = 0. All outputs are 0.
- Target capture:
  - On frame_start_i, if month_i < MONTH_CNT, target <= month_i.
  - Out-of-range month_i is ignored; target is kept.
- State machine: all transitions and off updates happen only on frame_start_i cycles.
  - SHOW: if target != disp_month, go to ROLL_OUT with off = 0. Otherwise stay.
  - ROLL_OUT: off <= min(off + ROLL_STEP, IMG_H). When the updated off reaches IMG_H: disp_month <= target, go to ROLL_IN with off = IMG_H.
  - ROLL_IN: off <= max(off - ROLL_STEP, 0), saturating at 0. When off reaches 0: go to ROLL_OUT if target != disp_month, else SHOW.
  - A target change during ROLL_OUT is absorbed: the swap uses the target at swap time.
  - A target change during ROLL_IN completes the roll-in first.
- Comparison timing: the target used in the frame_start comparison is the value captured in that same cycle. A new month is therefore acted on the same frame it is sampled.
- roll_busy_o = (state != SHOW), registered.
- Window and row mapping (stage 1, registered):
  - Window test: in_win = pix_de_i && WIN_X <= x < WIN_X+IMG_W && WIN_Y <= y < WIN_Y+IMG_H.
  - Relative coordinates: rx = x - WIN_X, ry = y - WIN_Y.
  - SHOW: my = ry.
  - ROLL_OUT: my = ry + off; row is blank if ry + off >= IMG_H.
  - ROLL_IN: row is blank if ry < off; otherwise my = ry - off.
  - Memory drive: mem_pos_x_o = rx + MEM_X_OFFSET, mem_pos_y_o = my, mem_month_o = disp_month.
  - When not in_win or blank: memory outputs hold their previous values, and vis = 0 is carried.
- Stage 2: pix_o = vis_d & mem_pix_i; pix_de_o = pix_de_i delayed 2 cycles.
  - Total latency from raster input to pix_o: 2 cycles.
- Simultaneous events: pixels in the frame_start_i cycle use the old state/off. New values apply from the next cycle.
- Arithmetic: internal sums must be at least PIX_Y_W+1 bits wide so off + ry does not wrap.
- Reset mid-roll: immediate return to reset values; disp_month = 0 with no roll.

Test Plan:
1. Reset with month_i = 0, raster at x=200+10, y=40+5, mem_pix_i = 1 → after 2 cycles pix_o=1, pix_de_o=1; mem_pos_x_o=94, mem_pos_y_o=5, mem_month_o=0.
2. Raster at x=199 or x=330 (outside window), mem_pix_i = 1 → pix_o=0; pix_de_o still follows pix_de_i with 2-cycle delay.
3. month_i 0→4 before a frame_start → roll_busy_o=1.
   - 10 frames of ROLL_OUT (off 3,6,…,30); disp_month_o=4 at the 10th.
   - 10 frames of ROLL_IN (off 27…0), then SHOW with roll_busy_o=0.
   - Check on frame 2 of ROLL_OUT (off=6): ry=20 → mem_pos_y_o=26; ry=25 → pix_o=0.
4. Change month_i 4→7 during ROLL_OUT → disp_month_o becomes 7 directly at swap, single roll. Change 7→2 during ROLL_IN → after off=0, immediate second ROLL_OUT to 2.
5. month_i=13 at frame_start → target unchanged, no roll. frame_start_i coincident with in-window pixel → that pixel uses pre-update off.
6. rst_i asserted at ROLL_OUT off=15 → next cycle roll_busy_o=0, disp_month_o=0, all outputs 0.
